reg_file_pipelined: RTL and testbench

//  Parametrised next-generation register file for the datapath: DEPTH x WIDTH storage,
//  one write port, two read ports with registered (1-cycle) reads and a read-valid flag.

---
 rtl/reg_file_pipelined.sv | 211 +++++++++++++++++++++
 tb/tb_reg_file_pipelined.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_pipelined.sv
// -----------------------------------------------------------------------------
// reg_file_pipelined
//
// Purpose
//   DEPTH x WIDTH datapath register file with one write port and two read
//   ports. Reads are registered: a request accepted on one rising edge
//   produces data and a one-cycle Read_Valid_o pulse right after that edge.
//   Register 0 can be hardwired to zero, and a sequential clear engine zeroes
//   one register per cycle while Busy_o is high.
//
// Configuration
//   RF_BYPASS_EN (macro) : when defined, a read that hits the register being
//                          written on the same edge returns Write_Data_i
//                          (write-through forwarding), independently per port.
//                          When undefined, that read returns the old contents.
//
// Parameters
//   WIDTH    : data width of each register
//   DEPTH    : number of registers (>= 2, need not be a power of two)
//   ZERO_REG : 1 = register 0 reads as zero and ignores writes
//   SEL      : address width, derived from DEPTH (do not override)
//
// Ports
//   clk               : rising-edge clock
//   rst               : asynchronous reset, active low
//   Reg_Write_i       : write enable
//   Write_Register_i  : write address
//   Write_Data_i      : write data
//   Read_En_i         : read request for both read ports
//   Read_Register_1_i : read address, port 1
//   Read_Register_2_i : read address, port 2
//   Clear_i           : request to zero every register
//   Read_Data_1_o     : registered read data, port 1
//   Read_Data_2_o     : registered read data, port 2
//   Read_Valid_o      : high for one cycle when read data was updated
//   Busy_o            : high while the clear engine runs
// -----------------------------------------------------------------------------
module reg_file_pipelined #(
  parameter int WIDTH    = 32'sd32,
  parameter int DEPTH    = 32'sd32,
  parameter int ZERO_REG = 32'sd1,
  parameter int SEL      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Reg_Write_i,
  input  logic [SEL-1:0]   Write_Register_i,
  input  logic [WIDTH-1:0] Write_Data_i,
  input  logic             Read_En_i,
  input  logic [SEL-1:0]   Read_Register_1_i,
  input  logic [SEL-1:0]   Read_Register_2_i,
  input  logic             Clear_i,
  output logic [WIDTH-1:0] Read_Data_1_o,
  output logic [WIDTH-1:0] Read_Data_2_o,
  output logic             Read_Valid_o,
  output logic             Busy_o
);

  // Clear engine states
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // DEPTH held one bit wider than an address so DEPTH == 2**SEL still fits
  localparam logic [SEL:0]   DEPTH_L  = (SEL+1)'(DEPTH);
  localparam logic [SEL-1:0] LAST_IDX = SEL'(DEPTH - 32'sd1);
  localparam logic [SEL-1:0] ADDR_ONE = SEL'(1'b1);
  localparam logic [SEL-1:0] ADDR_ZRO = {SEL{1'b0}};
  localparam logic [WIDTH-1:0] DATA_ZRO = {WIDTH{1'b0}};
  localparam bit HARD_ZERO = (ZERO_REG != 32'sd0);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [0:0]       state_r;
  logic [0:0]       state_n_s;
  logic [SEL-1:0]   clr_idx_r;
  logic [SEL-1:0]   clr_idx_n_s;
  logic             busy_r;
  logic             idle_s;
  logic             wr_accept_s;
  logic             wr_fire_s;
  logic             rd_accept_s;
  logic [WIDTH-1:0] rd_data_1_s;
  logic [WIDTH-1:0] rd_data_2_s;
  logic [WIDTH-1:0] rd_data_1_r;
  logic [WIDTH-1:0] rd_data_2_r;
  logic             rd_valid_r;

  // An address is "live" when it maps to real storage that is neither out of
  // range nor the hardwired zero register; only live addresses are written,
  // read back or forwarded.
  function automatic logic addr_live(input logic [SEL-1:0] a);
    logic ok;
    ok = ({1'b0, a} < DEPTH_L);
    if (HARD_ZERO && (a == ADDR_ZRO)) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    return ok;
  endfunction

  // Value a read port returns this edge; dead addresses read as zero.
  function automatic logic [WIDTH-1:0] read_port(input logic [SEL-1:0] a);
    logic [WIDTH-1:0] v;
    v = DATA_ZRO;
    if (addr_live(a)) begin
      v = mem_r[a];
    end else begin
      v = DATA_ZRO;
    end
`ifdef RF_BYPASS_EN
    // wr_fire_s already excludes dead addresses, so register 0 never forwards
    if (wr_fire_s && (Write_Register_i == a)) begin
      v = Write_Data_i;
    end else begin
      v = v;
    end
`endif
    return v;
  endfunction

  // Request qualification: a clear request in IDLE outranks reads and writes
  always_comb begin
    idle_s      = (state_r == ST_IDLE);
    wr_accept_s = Reg_Write_i && idle_s && !Clear_i;
    rd_accept_s = Read_En_i && idle_s && !Clear_i;
    wr_fire_s   = wr_accept_s && addr_live(Write_Register_i);
  end

  // Read data selection for both ports
  always_comb begin
    rd_data_1_s = read_port(Read_Register_1_i);
    rd_data_2_s = read_port(Read_Register_2_i);
  end

  // Clear engine next-state logic; Clear_i is ignored once clearing started
  always_comb begin
    state_n_s   = state_r;
    clr_idx_n_s = clr_idx_r;
    case (state_r)
      ST_IDLE: begin
        if (Clear_i) begin
          state_n_s   = ST_CLEAR;
          clr_idx_n_s = ADDR_ZRO;
        end else begin
          state_n_s   = ST_IDLE;
          clr_idx_n_s = clr_idx_r;
        end
      end
      ST_CLEAR: begin
        if (clr_idx_r == LAST_IDX) begin
          state_n_s   = ST_IDLE;
          clr_idx_n_s = ADDR_ZRO;
        end else begin
          state_n_s   = ST_CLEAR;
          clr_idx_n_s = clr_idx_r + ADDR_ONE;
        end
      end
      default: begin
        state_n_s   = ST_IDLE;
        clr_idx_n_s = ADDR_ZRO;
      end
    endcase
  end

  // Clear engine state, index and busy flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      clr_idx_r <= ADDR_ZRO;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      clr_idx_r <= clr_idx_n_s;
      busy_r    <= (state_n_s == ST_CLEAR);
    end
  end

  // Storage: clear engine has priority; writes are already blocked while busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= DATA_ZRO;
      end
    end else if (state_r == ST_CLEAR) begin
      mem_r[clr_idx_r] <= DATA_ZRO;
    end else if (wr_fire_s) begin
      mem_r[Write_Register_i] <= Write_Data_i;
    end
  end

  // Registered read outputs; data holds when no read is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_1_r <= DATA_ZRO;
      rd_data_2_r <= DATA_ZRO;
      rd_valid_r  <= 1'b0;
    end else if (rd_accept_s) begin
      rd_data_1_r <= rd_data_1_s;
      rd_data_2_r <= rd_data_2_s;
      rd_valid_r  <= 1'b1;
    end else begin
      rd_valid_r  <= 1'b0;
    end
  end

  assign Read_Data_1_o = rd_data_1_r;
  assign Read_Data_2_o = rd_data_2_r;
  assign Read_Valid_o  = rd_valid_r;
  assign Busy_o        = busy_r;

endmodule

// File: tb/tb_reg_file_pipelined.sv
// -----------------------------------------------------------------------------
// tb_reg_file_pipelined
//   Directed bench for reg_file_pipelined. Two instances share one stimulus:
//   dut_a uses the defaults (DEPTH 32, ZERO_REG 1), dut_b uses DEPTH 20 with
//   ZERO_REG 0 for the non-power-of-two and ordinary-register-0 cases.
//   Expected values are written by hand in the vector table and sequences.
// -----------------------------------------------------------------------------
module tb_reg_file_pipelined;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        rd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        clr;
  logic [31:0] a_d1, a_d2, b_d1, b_d2;
  logic        a_v, a_busy, b_v, b_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_file_pipelined dut_a (
    .clk(clk), .rst(rst), .Reg_Write_i(wr), .Write_Register_i(waddr),
    .Write_Data_i(wdata), .Read_En_i(rd), .Read_Register_1_i(ra1),
    .Read_Register_2_i(ra2), .Clear_i(clr), .Read_Data_1_o(a_d1),
    .Read_Data_2_o(a_d2), .Read_Valid_o(a_v), .Busy_o(a_busy)
  );

  reg_file_pipelined #(.WIDTH(32), .DEPTH(20), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .Reg_Write_i(wr), .Write_Register_i(waddr),
    .Write_Data_i(wdata), .Read_En_i(rd), .Read_Register_1_i(ra1),
    .Read_Register_2_i(ra2), .Clear_i(clr), .Read_Data_1_o(b_d1),
    .Read_Data_2_o(b_d2), .Read_Valid_o(b_v), .Busy_o(b_busy)
  );

  typedef struct {
    bit          wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    bit          rd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    bit          clr;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    bit          e_v;
    bit          e_busy;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit w, input logic [4:0] wa, input logic [31:0] wd,
                       input bit r, input logic [4:0] r1, input logic [4:0] r2,
                       input bit c);
    wr = w; waddr = wa; wdata = wd; rd = r; ra1 = r1; ra2 = r2; clr = c;
  endtask

  // one active edge, then sample on the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int a_cnt, b_cnt, vseen, cyc;

    //            wr  waddr  wdata          rd  ra1    ra2    clr  e_d1                       e_d2          v     busy
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  1'b0, 32'h0,                   32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd31, 1'b0, 32'h0,                   32'h0,        1'b1, 1'b0};
    vecs[2]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  1'b0, 32'h0,                   32'h0,        1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd5,  1'b0, 32'hDEADBEEF,            32'hDEADBEEF, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  1'b0, 32'hDEADBEEF,            32'hDEADBEEF, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  5'd0,  1'b0, 32'hDEADBEEF,            32'hDEADBEEF, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd5,  1'b0, 32'h0,                   32'hDEADBEEF, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 5'd7,  32'h11,       1'b0, 5'd0,  5'd0,  1'b0, 32'h0,                   32'hDEADBEEF, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 5'd7,  32'h22,       1'b1, 5'd7,  5'd5,  1'b0, BYP ? 32'h22 : 32'h11,   32'hDEADBEEF, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  1'b0, 32'h22,                  32'h22,       1'b1, 1'b0};
    vecs[10] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd31, 5'd30, 1'b0, BYP ? 32'hA5A5A5A5 : 32'h0, 32'h0,     1'b1, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 5'd0,  1'b0, 32'hA5A5A5A5,            32'h0,        1'b1, 1'b0};
    vecs[12] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  1'b0, 32'h0,                   32'h0,        1'b1, 1'b0};
    vecs[13] = '{1'b1, 5'd6,  32'h66,       1'b1, 5'd5,  5'd6,  1'b0, 32'hDEADBEEF,            BYP ? 32'h66 : 32'h0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  5'd7,  1'b0, 32'h66,                  32'h22,       1'b1, 1'b0};

    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // ---------------- table-driven vectors on dut_a ----------------
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].wr, vecs[i].waddr, vecs[i].wdata, vecs[i].rd,
            vecs[i].ra1, vecs[i].ra2, vecs[i].clr);
      tick();
      check($sformatf("vec%0d_d1", i), {64'h0, a_d1}, {64'h0, vecs[i].e_d1});
      check($sformatf("vec%0d_d2", i), {64'h0, a_d2}, {64'h0, vecs[i].e_d2});
      check($sformatf("vec%0d_valid", i), {95'h0, a_v}, {95'h0, vecs[i].e_v});
      check($sformatf("vec%0d_busy", i), {95'h0, a_busy}, {95'h0, vecs[i].e_busy});
    end

    // ---------------- fill, then clear with a colliding write/read ----------------
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 5'd0, 1'b0);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd31, 1'b0);
    tick();
    check("fill_read", {32'h0, a_d1, a_d2}, {32'h0, 32'h103, 32'h11F});

    drive(1'b1, 5'd3, 32'hBAD, 1'b1, 5'd3, 5'd3, 1'b1);
    tick();
    check("clr_start_busy", {94'h0, a_busy, b_busy}, {94'h0, 1'b1, 1'b1});
    check("clr_start_valid", {95'h0, a_v}, 96'h0);

    a_cnt = 1; b_cnt = 1; vseen = 0; cyc = 0;
    while ((a_busy || b_busy) && cyc < 100) begin
      drive(1'b1, 5'd9, 32'h999, 1'b1, 5'd9, 5'd9, (cyc < 5) ? 1'b1 : 1'b0);
      tick();
      cyc++;
      if (a_busy) a_cnt++;
      if (b_busy) b_cnt++;
      if (a_v) vseen++;
    end
    check("clr_timeout", {95'h0, (cyc < 100) ? 1'b1 : 1'b0}, {95'h0, 1'b1});
    check("clr_busy_len_a", 96'(a_cnt), 96'd32);
    check("clr_busy_len_b", 96'(b_cnt), 96'd20);
    check("clr_valid_during_busy", 96'(vseen), 96'd0);

    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(31 - i), 1'b0);
      tick();
      check($sformatf("post_clr_read%0d", i), {31'h0, a_v, a_d1, a_d2}, {31'h0, 1'b1, 64'h0});
    end

    // ---------------- reset in the middle of a clear ----------------
    drive(1'b1, 5'd10, 32'h55, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd10, 1'b0);
    tick();
    check("pre_rst_read", {32'h0, a_d1, a_d2}, {32'h0, 32'h55, 32'h55});
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    check("mid_clr_busy", {94'h0, a_busy, b_busy}, {94'h0, 1'b1, 1'b1});
    #2 rst = 1'b0;
    #1;
    check("rst_outputs_a", {30'h0, a_busy, a_v, a_d1, a_d2}, 96'h0);
    check("rst_busy_b", {95'h0, b_busy}, 96'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("rst_release_valid", {95'h0, a_v}, 96'h0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(31 - i), 1'b0);
      tick();
      check($sformatf("post_rst_read%0d", i), {31'h0, a_v, a_d1, a_d2}, {31'h0, 1'b1, 64'h0});
    end

    // ---------------- ZERO_REG=0 and DEPTH=20 on dut_b ----------------
    drive(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 1'b0);
    tick();
    check("r0_zero_reg1", {64'h0, a_d1}, 96'h0);
    check("r0_zero_reg0", {32'h0, b_d1, b_d2}, {32'h0, 32'h12345678, 32'h12345678});

    drive(1'b1, 5'd25, 32'hCAFE0001, 1'b1, 5'd25, 5'd19, 1'b0);
    tick();
    check("oor_same_edge_b", {31'h0, b_v, b_d1, b_d2}, {31'h0, 1'b1, 64'h0});
    drive(1'b1, 5'd19, 32'h13, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd25, 5'd19, 1'b0);
    tick();
    check("oor_read_b", {32'h0, b_d1, b_d2}, {32'h0, 32'h0, 32'h13});
    check("inrange25_a", {32'h0, a_d1, a_d2}, {32'h0, 32'hCAFE0001, 32'h13});
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 1'b0);
    tick();
    check("oor_no_alias_b", {32'h0, b_d1, b_d2}, {32'h0, 32'h0, 32'h12345678});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
